// File: rtl/execute_stage_md_if.sv
// rtl/execute_stage_md_if.sv - decode/hazard-side bundle for the execute stage with mul/div
// Purpose: carries every non-clock signal of execute_stage_md.
// Ports (signals):
//   from decode/hazard unit: StallE, FlushE, *D controls, RD1D/RD2D/SignImmD,
//                            RsD/RtD/RdD, shamtD, ResultW, ALUOutM, ForwardAE/BE
//   to EX/MEM and hazard:    RegWriteE, MemtoRegE, MemWriteE, RsE, RtE, WriteRegE,
//                            WriteDataE, ALUOutE, MDBusyE, MDHazardE, HI, LO
// Modports: master = pipeline/hazard side, slave = execute stage.
interface execute_stage_md_if #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5,
  parameter int SHBITS  = 5
) ();
  logic               StallE, FlushE;
  logic               RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [3:0]         ALUControlD;
  logic [2:0]         MDOpD;
  logic [WIDTH-1:0]   RD1D, RD2D, SignImmD;
  logic [REGBITS-1:0] RsD, RtD, RdD;
  logic [SHBITS-1:0]  shamtD;
  logic [WIDTH-1:0]   ResultW, ALUOutM;
  logic [1:0]         ForwardAE, ForwardBE;

  logic               RegWriteE, MemtoRegE, MemWriteE;
  logic [REGBITS-1:0] RsE, RtE, WriteRegE;
  logic [WIDTH-1:0]   WriteDataE, ALUOutE;
  logic               MDBusyE, MDHazardE;
  logic [WIDTH-1:0]   HI, LO;

  modport master (
    output StallE, FlushE, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
           ALUControlD, MDOpD, RD1D, RD2D, SignImmD, RsD, RtD, RdD, shamtD,
           ResultW, ALUOutM, ForwardAE, ForwardBE,
    input  RegWriteE, MemtoRegE, MemWriteE, RsE, RtE, WriteRegE, WriteDataE,
           ALUOutE, MDBusyE, MDHazardE, HI, LO
  );

  modport slave (
    input  StallE, FlushE, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
           ALUControlD, MDOpD, RD1D, RD2D, SignImmD, RsD, RtD, RdD, shamtD,
           ResultW, ALUOutM, ForwardAE, ForwardBE,
    output RegWriteE, MemtoRegE, MemWriteE, RsE, RtE, WriteRegE, WriteDataE,
           ALUOutE, MDBusyE, MDHazardE, HI, LO
  );
endinterface

// File: rtl/execute_stage_md.sv
// rtl/execute_stage_md.sv - MIPS execute stage with forwarding, ALU and iterative mul/div
// Purpose: D->E pipeline register (stall/flush), operand forwarding, ALU, and a
//          radix-2 multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - execute_stage_md_if.slave: decode inputs, forwarded values, forward
//           selects, stall/flush in; registered controls, indices, ALU result,
//           store data, mul/div busy/hazard and HI/LO out.
module execute_stage_md #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5,
  parameter int SHBITS  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  execute_stage_md_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MFHI  = 3'd5;
  localparam logic [2:0] OP_MFLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} md_state_t;

  // E pipeline register
  logic               regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e;
  logic [3:0]         aluctl_e;
  logic [2:0]         mdop_e;
  logic [WIDTH-1:0]   rd1_e, rd2_e, imm_e;
  logic [REGBITS-1:0] rs_e, rt_e, rd_e;
  logic [SHBITS-1:0]  shamt_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.FlushE) begin
      regwrite_e <= 1'b0; memtoreg_e <= 1'b0; memwrite_e <= 1'b0;
      alusrc_e   <= 1'b0; regdst_e   <= 1'b0;
      aluctl_e   <= '0;   mdop_e     <= '0;
      rd1_e      <= '0;   rd2_e      <= '0;   imm_e <= '0;
      rs_e       <= '0;   rt_e       <= '0;   rd_e  <= '0;
      shamt_e    <= '0;
    end else if (!bus.StallE) begin
      regwrite_e <= bus.RegWriteD; memtoreg_e <= bus.MemtoRegD; memwrite_e <= bus.MemWriteD;
      alusrc_e   <= bus.ALUSrcD;   regdst_e   <= bus.RegDstD;
      aluctl_e   <= bus.ALUControlD; mdop_e   <= bus.MDOpD;
      rd1_e      <= bus.RD1D;      rd2_e      <= bus.RD2D;      imm_e <= bus.SignImmD;
      rs_e       <= bus.RsD;       rt_e       <= bus.RtD;       rd_e  <= bus.RdD;
      shamt_e    <= bus.shamtD;
    end
  end

  // Forwarding and ALU
  logic [WIDTH-1:0] src_a, src_b, wdata, alu_y;
  logic             slt_s, slt_u;

  always_comb begin
    case (bus.ForwardAE)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = bus.ALUOutM;
      default: src_a = rd1_e;
    endcase
    case (bus.ForwardBE)
      2'b01:   wdata = bus.ResultW;
      2'b10:   wdata = bus.ALUOutM;
      default: wdata = rd2_e;
    endcase
    src_b = alusrc_e ? imm_e : wdata;
    slt_s = $signed(src_a) < $signed(src_b);
    slt_u = src_a < src_b;
    case (aluctl_e)
      4'd0:    alu_y = src_a & src_b;
      4'd1:    alu_y = src_a | src_b;
      4'd2:    alu_y = src_a + src_b;
      4'd3:    alu_y = src_a ^ src_b;
      4'd4:    alu_y = src_b << shamt_e;
      4'd5:    alu_y = src_b >> shamt_e;
      4'd6:    alu_y = src_a - src_b;
      4'd7:    alu_y = {{(WIDTH-1){1'b0}}, slt_s};
      4'd8:    alu_y = $signed(src_b) >>> shamt_e;
      4'd9:    alu_y = ~(src_a | src_b);
      4'd10:   alu_y = {{(WIDTH-1){1'b0}}, slt_u};
      default: alu_y = '0;
    endcase
  end

  // Multiply/divide unit
  md_state_t        state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] md_hi, md_lo, md_b, hi_q, lo_q;
  logic             neg_lo, neg_hi, div0;

  logic             md_busy, md_hazard, md_start, md_is_mul, md_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    md_busy   = (state != S_IDLE);
    md_hazard = md_busy && (mdop_e >= OP_MULT) && (mdop_e <= OP_MFLO);
    md_start  = !md_busy && !md_hazard && !bus.StallE &&
                (mdop_e >= OP_MULT) && (mdop_e <= OP_DIVU);
    md_is_mul = (mdop_e == OP_MULT) || (mdop_e == OP_MULTU);
    md_signed = (mdop_e == OP_MULT) || (mdop_e == OP_DIV);
    a_neg     = md_signed && src_a[WIDTH-1];
    b_neg     = md_signed && wdata[WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -wdata : wdata;
  end

  // One radix-2 step. Multiply: md_hi:md_lo is the partial product with the
  // multiplier shifting out of md_lo. Divide: md_lo shifts the dividend out
  // and the quotient in, md_hi holds the partial remainder.
  logic [WIDTH:0]     mul_sum, div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff, hi_n, lo_n, quo, rem;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    mul_sum  = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
    div_sh   = {md_hi, md_lo[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, md_b};
    div_diff = div_sh[WIDTH-1:0] - md_b;
    if (state == S_MUL) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], md_lo[WIDTH-1:1]};
    end else begin
      hi_n = div_ge ? div_diff : div_sh[WIDTH-1:0];
      lo_n = {md_lo[WIDTH-2:0], div_ge};
    end
    prod     = {hi_n, lo_n};
    prod_fix = neg_lo ? -prod : prod;
    // A zero divisor yields an all-ones quotient regardless of sign; the
    // remainder path already reproduces the dividend.
    quo      = div0 ? '1 : (neg_lo ? -lo_n : lo_n);
    rem      = neg_hi ? -hi_n : hi_n;
    res_hi   = (state == S_MUL) ? prod_fix[2*WIDTH-1:WIDTH] : rem;
    res_lo   = (state == S_MUL) ? prod_fix[WIDTH-1:0]       : quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      md_hi  <= '0; md_lo <= '0; md_b <= '0;
      hi_q   <= '0; lo_q  <= '0;
      neg_lo <= 1'b0; neg_hi <= 1'b0; div0 <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_start) begin
            state  <= md_is_mul ? S_MUL : S_DIV;
            count  <= CW'(WIDTH);
            md_hi  <= '0;
            md_lo  <= md_is_mul ? b_mag : a_mag;
            md_b   <= md_is_mul ? a_mag : b_mag;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            div0   <= (wdata == '0);
          end
        end
        default: begin
          md_hi <= hi_n;
          md_lo <= lo_n;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= S_IDLE;
            hi_q  <= res_hi;
            lo_q  <= res_lo;
          end
        end
      endcase
    end
  end

  assign bus.RegWriteE  = regwrite_e;
  assign bus.MemtoRegE  = memtoreg_e;
  assign bus.MemWriteE  = memwrite_e;
  assign bus.RsE        = rs_e;
  assign bus.RtE        = rt_e;
  assign bus.WriteRegE  = regdst_e ? rd_e : rt_e;
  assign bus.WriteDataE = wdata;
  assign bus.ALUOutE    = (mdop_e == OP_MFHI) ? hi_q :
                          (mdop_e == OP_MFLO) ? lo_q : alu_y;
  assign bus.MDBusyE    = md_busy;
  assign bus.MDHazardE  = md_hazard;
  assign bus.HI         = hi_q;
  assign bus.LO         = lo_q;
endmodule

// File: tb/tb_execute_stage_md.sv
// tb/tb_execute_stage_md.sv - directed and randomized bench for execute_stage_md
module tb_execute_stage_md;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  execute_stage_md_if #(.WIDTH(W), .REGBITS(5), .SHBITS(5)) bus ();

  execute_stage_md #(.WIDTH(W), .REGBITS(5), .SHBITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    bus.RegWriteD = 0; bus.MemtoRegD = 0; bus.MemWriteD = 0; bus.ALUSrcD = 0; bus.RegDstD = 0;
    bus.ALUControlD = 0; bus.MDOpD = 0; bus.RD1D = 0; bus.RD2D = 0; bus.SignImmD = 0;
    bus.RsD = 0; bus.RtD = 0; bus.RdD = 0; bus.shamtD = 0;
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] ones;
    ones = 32'hFFFFFFFF;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return b << sh;
      4'd5:  return b >> sh;
      4'd6:  return a - b;
      4'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd8:  return (b >> sh) | (b[31] ? ~(ones >> sh) : 32'd0);
      4'd9:  return ~(a | b);
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Returns {HI, LO}
  function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub;
    longint      p;
    int          q, r;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {r, q};
      end
      3'd4: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issues one mul/div, counts busy cycles, then checks HI/LO against the model.
  task automatic do_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit disturb);
    int          cycles;
    logic [63:0] exp;
    bus.ForwardAE = 0; bus.ForwardBE = 0;
    clear_d();
    bus.MDOpD = op; bus.RD1D = a; bus.RD2D = b;
    tick();
    clear_d();
    tick();
    cycles = 0;
    while (bus.MDBusyE && cycles < 100) begin
      cycles++;
      if (disturb) begin
        bus.FlushE = 1'b1;
        bus.StallE = 1'($urandom_range(0, 1));
      end
      tick();
    end
    bus.FlushE = 0; bus.StallE = 0;
    exp = md_ref(op, a, b);
    check({tag, "_busy_cycles"}, cycles, W);
    check({tag, "_hi"}, bus.HI, exp[63:32]);
    check({tag, "_lo"}, bus.LO, exp[31:0]);
  endtask

  initial begin
    int          cycles;
    bit          hz_all;
    logic [31:0] a, b, imm, rw, am, src_a, wd, src_b;
    logic [3:0]  op;
    logic [4:0]  sh, rt, rd;
    logic [1:0]  fa, fb;
    bit          asrc, rdst;
    logic [2:0]  mop;

    bus.StallE = 0; bus.FlushE = 0; bus.ResultW = 0; bus.ALUOutM = 0;
    bus.ForwardAE = 0; bus.ForwardBE = 0;
    clear_d();
    bus.RegWriteD = 1; bus.RD1D = 32'h1234; bus.RegDstD = 1; bus.RdD = 7;
    #12;
    check("rst_busy", bus.MDBusyE, 0);
    check("rst_hi", bus.HI, 0);
    check("rst_lo", bus.LO, 0);
    check("rst_aluout", bus.ALUOutE, 0);
    check("rst_writereg", bus.WriteRegE, 0);
    check("rst_regwrite", bus.RegWriteE, 0);
    clear_d();
    tick();
    rst_n = 1;
    tick();

    // Forwarding into SUB, then flush
    bus.RD1D = 42; bus.ALUControlD = 6; bus.RegDstD = 1; bus.RdD = 16; bus.RegWriteD = 1;
    tick();
    bus.ResultW = 32; bus.ALUOutM = 22; bus.ForwardAE = 2; bus.ForwardBE = 1;
    #1;
    check("fwd_sub", bus.ALUOutE, 32'hFFFFFFF6);
    check("fwd_wdata", bus.WriteDataE, 32);
    check("writereg_rd", bus.WriteRegE, 16);
    check("regwrite_e", bus.RegWriteE, 1);
    bus.FlushE = 1;
    tick();
    bus.FlushE = 0;
    check("flush_writereg", bus.WriteRegE, 0);
    check("flush_regwrite", bus.RegWriteE, 0);
    bus.ForwardAE = 0; bus.ForwardBE = 0;
    clear_d();

    // Shifts, compares, undefined op
    bus.ALUSrcD = 1; bus.SignImmD = 32'h80000000; bus.shamtD = 4; bus.ALUControlD = 8;
    tick();
    check("sra", bus.ALUOutE, 32'hF8000000);
    bus.ALUControlD = 5;
    tick();
    check("srl", bus.ALUOutE, 32'h08000000);
    bus.RD1D = 32'hFFFFFFFF; bus.SignImmD = 1; bus.ALUControlD = 7;
    tick();
    check("slt", bus.ALUOutE, 1);
    bus.ALUControlD = 10;
    tick();
    check("sltu", bus.ALUOutE, 0);
    bus.ALUControlD = 15;
    tick();
    check("op15", bus.ALUOutE, 0);
    clear_d();

    // Random ALU ops with random forwarding against the model
    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; imm = $urandom;
      rw = $urandom; am = $urandom; sh = 5'($urandom); fa = 2'($urandom); fb = 2'($urandom);
      asrc = 1'($urandom); rdst = 1'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      bus.ALUControlD = op; bus.RD1D = a; bus.RD2D = b; bus.SignImmD = imm; bus.shamtD = sh;
      bus.ALUSrcD = asrc; bus.RegDstD = rdst; bus.RtD = rt; bus.RdD = rd;
      tick();
      bus.ResultW = rw; bus.ALUOutM = am; bus.ForwardAE = fa; bus.ForwardBE = fb;
      #1;
      src_a = (fa == 1) ? rw : (fa == 2) ? am : a;
      wd    = (fb == 1) ? rw : (fb == 2) ? am : b;
      src_b = asrc ? imm : wd;
      check($sformatf("rand_alu%0d_op%0d", i, op), bus.ALUOutE, alu_ref(op, src_a, src_b, sh));
      check($sformatf("rand_wdata%0d", i), bus.WriteDataE, wd);
      check($sformatf("rand_wreg%0d", i), bus.WriteRegE, rdst ? rd : rt);
    end
    bus.ForwardAE = 0; bus.ForwardBE = 0;
    clear_d();
    tick();

    // MULT -3 x 7 with MFLO stalled behind it
    bus.MDOpD = 1; bus.RD1D = 32'hFFFFFFFD; bus.RD2D = 7;
    tick();
    clear_d();
    bus.MDOpD = 6;
    tick();
    clear_d();
    cycles = 0; hz_all = 1;
    while (bus.MDBusyE && cycles < 100) begin
      cycles++;
      hz_all &= bus.MDHazardE;
      bus.StallE = bus.MDHazardE;
      tick();
    end
    bus.StallE = bus.MDHazardE;
    #1;
    check("mult_busy_cycles", cycles, 32);
    check("mflo_hazard_held", hz_all, 1);
    check("hazard_released", bus.MDHazardE, 0);
    check("mult_hi", bus.HI, 32'hFFFFFFFF);
    check("mult_lo", bus.LO, 32'hFFFFFFEB);
    check("mflo_aluout", bus.ALUOutE, 32'hFFFFFFEB);
    bus.StallE = 0;
    tick();

    // Directed divides
    do_md("divu_100_7", 3'd4, 100, 7, 0);
    check("divu_lo_const", bus.LO, 14);
    check("divu_hi_const", bus.HI, 2);
    do_md("div_m7_2", 3'd3, 32'hFFFFFFF9, 2, 0);
    check("div_lo_const", bus.LO, 32'hFFFFFFFD);
    check("div_hi_const", bus.HI, 32'hFFFFFFFF);
    do_md("div_5_0", 3'd3, 5, 0, 0);
    check("div0_lo_const", bus.LO, 32'hFFFFFFFF);
    check("div0_hi_const", bus.HI, 5);
    do_md("div_min_m1", 3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    check("divmin_lo_const", bus.LO, 32'h80000000);
    check("divmin_hi_const", bus.HI, 0);

    // Random mul/div, some with flush/stall while busy
    for (int i = 0; i < 6; i++) begin
      mop = 3'($urandom_range(1, 4));
      a = $urandom;
      b = (i == 2) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 300)) : $urandom);
      do_md($sformatf("rand_md%0d_op%0d", i, mop), mop, a, b, 1'($urandom));
    end

    // Stall holds, stall+flush clears
    bus.RD1D = 5; bus.ALUSrcD = 1; bus.SignImmD = 3; bus.ALUControlD = 2; bus.RegWriteD = 1;
    tick();
    check("pre_stall_add", bus.ALUOutE, 8);
    bus.StallE = 1;
    bus.RD1D = 100; bus.SignImmD = 100; bus.ALUControlD = 3; bus.RegWriteD = 0;
    tick();
    check("stall_aluout", bus.ALUOutE, 8);
    check("stall_regwrite", bus.RegWriteE, 1);
    bus.FlushE = 1;
    tick();
    check("stallflush_regwrite", bus.RegWriteE, 0);
    check("stallflush_aluout", bus.ALUOutE, 0);
    bus.FlushE = 0; bus.StallE = 0;
    clear_d();
    tick();

    do_md("multu_flush", 3'd2, 32'hFFFFFFFF, 2, 1);
    check("multu_hi_const", bus.HI, 1);
    check("multu_lo_const", bus.LO, 32'hFFFFFFFE);

    // Reset aborts an in-flight DIV
    bus.MDOpD = 3; bus.RD1D = 1000; bus.RD2D = 3; bus.RegDstD = 1; bus.RdD = 9;
    tick();
    bus.MDOpD = 0;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("prereset_busy", bus.MDBusyE, 1);
    check("prereset_writereg", bus.WriteRegE, 9);
    rst_n = 0;
    #1;
    check("abort_busy", bus.MDBusyE, 0);
    check("abort_hi", bus.HI, 0);
    check("abort_lo", bus.LO, 0);
    check("abort_writereg", bus.WriteRegE, 0);
    check("abort_aluout", bus.ALUOutE, 0);
    clear_d();
    tick();
    rst_n = 1;
    tick();
    tick();
    check("post_reset_busy", bus.MDBusyE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
